// File: rtl/gpio_bridge_pkg.sv
// Shared defaults and width helpers for the GPIO board-side bridge.
package gpio_bridge_pkg;

    localparam int DEF_WIDTH           = 32;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FIFO_DEPTH      = 8;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the debounce down-counter, which must hold cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead capture FIFO: head word is presented combinationally while non-empty.
module sync_fifo
    import gpio_bridge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_pop_ready,
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_data,
    output logic [ptr_width(DEPTH):0]   o_count,
    output logic                        o_drop
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = !w_empty && i_pop_ready;
    // A pop in the same cycle frees the slot the push lands in, even when full.
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/gpio_io_bridge.sv
// Board-side GPIO partner: debounced switch word in, change-captured output word FIFO out.
module gpio_io_bridge
    import gpio_bridge_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              sw_in,
    output logic [WIDTH-1:0]              gpio_in,
    input  logic [WIDTH-1:0]              gpio_out,
    output logic                          host_valid,
    output logic [WIDTH-1:0]              host_data,
    input  logic                          host_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_ovf
);

    localparam int DCW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0] DB_LOAD = DCW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_cand;
    logic [DCW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_gpio_in;
    logic [WIDTH-1:0] r_prev_out;
    logic             r_overflow;

    logic             w_change;
    logic             w_drop;

    // Whole-word debounce: any change of the synchronised word reloads one
    // shared timer; the candidate commits once the timer has run out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_gpio_in <= '0;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= DB_LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - DCW'(1);
            end else if (r_cand != r_gpio_in) begin
                r_gpio_in <= r_cand;
            end
        end
    end

    assign gpio_in  = r_gpio_in;
    assign w_change = (gpio_out != r_prev_out);

    // prev_out tracks every change, including dropped ones, so a lost word is not retried.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_out <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_change) begin
                r_prev_out <= gpio_out;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign overflow = r_overflow;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_change),
        .i_data      (gpio_out),
        .i_pop_ready (host_ready),
        .o_valid     (host_valid),
        .o_data      (host_data),
        .o_count     (fifo_count),
        .o_drop      (w_drop)
    );

endmodule

// File: tb/tb_gpio_io_bridge.sv
// Scoreboard bench for gpio_io_bridge: queue-based reference model plus negedge monitor.
module tb_gpio_io_bridge;

    localparam int W     = 32;
    localparam int D     = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  sw_in;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  gpio_out;
    logic          host_valid;
    logic [W-1:0]  host_data;
    logic          host_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clear_ovf;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] samp_q[$];
    logic [W-1:0] m_prev = '0;
    logic [W-1:0] m_gpio = '0;
    logic         m_ovf  = 1'b0;

    always #5 clk = ~clk;

    gpio_io_bridge #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Sample history seen by the input path: each edge sees the switch word from two edges back.
    task automatic model_reset();
        exp_q.delete();
        samp_q.delete();
        for (int i = 0; i < D + 2; i++) samp_q.push_back('0);
        m_prev = '0;
        m_gpio = '0;
        m_ovf  = 1'b0;
    endtask

    // Reference model. gpio_in takes the word seen D+1 edges in a row; the output
    // path is a bounded queue of changed words.
    always @(posedge clk) begin : model
        bit           stable;
        bit           dropped;
        logic [W-1:0] seen;
        if (!rst) begin
            model_reset();
        end else begin
            seen   = samp_q[samp_q.size() - 2];
            stable = 1'b1;
            for (int i = samp_q.size() - 2 - D; i <= samp_q.size() - 2; i++)
                if (samp_q[i] != seen) stable = 1'b0;
            if (stable) m_gpio = seen;
            samp_q.push_back(sw_in);
            void'(samp_q.pop_front());

            dropped = 1'b0;
            if (gpio_out != m_prev) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(gpio_out);
                else dropped = 1'b1;
                m_prev = gpio_out;
            end
            if (dropped) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
        end
    end

    // Monitor: compares the DUT against the model between edges and retires accepted words.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("gpio_in", 64'(gpio_in), 64'(m_gpio));
            check("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
            check("host_valid", 64'(host_valid), 64'(exp_q.size() != 0));
            check("overflow", 64'(overflow), 64'(m_ovf));
            if (exp_q.size() != 0) begin
                check("host_data", 64'(host_data), 64'(exp_q[0]));
                if (host_ready) void'(exp_q.pop_front());
            end else begin
                check("host_data_empty", 64'(host_data), 64'(0));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bias;
        model_reset();
        rst        = 1'b0;
        sw_in      = '0;
        gpio_out   = '0;
        host_ready = 1'b0;
        clear_ovf  = 1'b0;
        tick(3);
        rst = 1'b1;

        // quiet after reset
        tick(20);

        // held switch word and a too-short pulse
        sw_in = 32'h0000_00A5;
        tick(12);
        sw_in = 32'h0000_00A4;
        tick(3);
        sw_in = 32'h0000_00A5;
        tick(12);

        // back-to-back captures, then drain
        gpio_out = 32'h11; tick();
        gpio_out = 32'h22; tick();
        gpio_out = 32'h33; tick();
        tick(3);
        host_ready = 1'b1;
        tick(5);
        host_ready = 1'b0;

        // overflow: nine captures into eight entries, then clear
        for (int v = 1; v <= 9; v++) begin
            gpio_out = W'(v);
            tick();
        end
        tick(2);
        clear_ovf = 1'b1; tick();
        clear_ovf = 1'b0; tick(2);

        // simultaneous push and pop while full
        gpio_out   = 32'hAB;
        host_ready = 1'b1;
        tick();
        host_ready = 1'b0;
        tick(2);
        host_ready = 1'b1;
        sw_in      = 32'h0F0F_0000;
        tick(3);

        // asynchronous reset mid-drain
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", 64'(fifo_count), 64'(0));
        check("async_rst_valid", 64'(host_valid), 64'(0));
        check("async_rst_gpio_in", 64'(gpio_in), 64'(0));
        check("async_rst_ovf", 64'(overflow), 64'(0));
        gpio_out   = '0;
        host_ready = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(10);

        // randomized traffic
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) bias = $urandom_range(10, 90);
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) sw_in = $urandom();
                else sw_in = sw_in ^ (W'(1) << $urandom_range(0, W - 1));
            end
            if ($urandom_range(0, 2) == 0) gpio_out = $urandom_range(0, 15);
            host_ready = ($urandom_range(1, 100) <= bias);
            clear_ovf  = ($urandom_range(0, 19) == 0);
            tick();
        end

        clear_ovf  = 1'b0;
        host_ready = 1'b1;
        tick(DEPTH + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_io_bridge.md
Name: gpio_io_bridge

Overview:
Board-side partner of the CPU's GPIO port. The CPU drives gpio_out and samples gpio_in; this block consumes the first and produces the second.
- Input path: asynchronous external switch bits are synchronised and word-debounced to produce gpio_in.
- Output path: every change of gpio_out is captured into a FIFO, which an external host drains through a valid/ready handshake.

Parameters:
- WIDTH, 32, GPIO word width.
- DEBOUNCE_CYCLES, 4, stable cycles required before gpio_in updates. Must be ≥1.
- FIFO_DEPTH, 8, capture FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- sw_in  in  WIDTH  raw asynchronous switch/pin inputs
- gpio_in  out  WIDTH  debounced word, to CPU gpio_in
- gpio_out  in  WIDTH  CPU gpio_out register
- host_valid  out  1  FIFO head valid
- host_data  out  WIDTH  FIFO head word
- host_ready  in  1  host accepts head this cycle
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: a capture was dropped
- clear_ovf  in  1  synchronous clear of overflow

Behaviour:
Reset (rst=0, asynchronous):
- Outputs: gpio_in=0, host_valid=0, host_data=0, fifo_count=0, overflow=0.
- Internal: sync flops=0, candidate=0, debounce counter=0, prev_out=0, FIFO pointers=0.

Input path (pipeline s1 -> s2 -> debounce, all registered):
- s1<=sw_in, s2<=s1.
- If s2!=cand: cand<=s2, cnt<=0.
- Else if cnt<DEBOUNCE_CYCLES-1: cnt++.
- Else if cand!=gpio_in: gpio_in<=cand.
- Latency: a change sampled at edge e0 and held stable appears on gpio_in after edge e0+DEBOUNCE_CYCLES+2. Example: D=4 gives e0+6.
- Any change of s2 before commit restarts the count. Pulses too short to complete the count never reach gpio_in.
- Whole-word debounce: one counter shared by all bits.

Output path (change capture):
- Each edge compares gpio_out with prev_out. On mismatch: push gpio_out and set prev_out<=gpio_out.
- prev_out resets to 0, matching the CPU's gpio_out reset value, so no capture occurs at reset.
- Back-to-back changes on consecutive cycles are each captured.

FIFO (show-ahead):
- host_valid = (fifo_count!=0).
- host_data = head entry; forced to 0 when empty.
- Pop when host_valid && host_ready.
- host_data and host_valid stay stable while host_valid && !host_ready.
- host_ready while empty has no effect.

FIFO boundary cases:
- Push with full FIFO and no pop: word dropped, overflow<=1, count stays FIFO_DEPTH. prev_out still updates, so the same value is not retried.
- Push and pop in the same cycle, including when full: both occur and count is unchanged. Overflow is not set.
- Push into an empty FIFO: host_valid=1 and host_data=new word after that edge. There is no bypass of the push edge.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty are derived from fifo_count.

Overflow flag:
- clear_ovf=1 clears overflow at the next edge.
- A simultaneous drop takes priority: overflow stays 1.

Reset mid-operation:
- Reset empties the FIFO and abandons any in-progress debounce.
- After release, the first edge behaves as from power-up.

Decomposition:
- Package gpio_bridge_pkg holds the defaults for WIDTH, FIFO_DEPTH and DEBOUNCE_CYCLES, plus a function computing the pointer width.
- Sub-module sync_fifo covers: storage array, pointers, count, push/pop, full/empty, and a drop output that the top block turns into overflow.
- Synchroniser, debounce and change-detect logic stay in gpio_io_bridge.

Test Plan:
1. Reset release with sw_in=0, gpio_out=0, held 20 cycles -> gpio_in=0, host_valid=0, fifo_count=0, overflow=0. No capture occurs.
2. sw_in 0 -> 0x0000_00A5 sampled at edge e0, held (D=4) -> gpio_in=0 through edge e0+5, =0x0000_00A5 after edge e0+6.
3. sw_in pulses to 0x1 for 3 cycles, then returns to 0 -> gpio_in stays 0 throughout.
4. gpio_out=0x11, then 0x22, then 0x33 on consecutive cycles, host_ready=0 -> fifo_count=3, host_data=0x11. Then host_ready=1 -> host_data reads 0x11, 0x22, 0x33 on successive cycles, then host_valid=0.
5. Nine distinct gpio_out values with host_ready=0 (depth 8) -> fifo_count=8, overflow=1. Entries are values 1..8, ninth dropped. clear_ovf pulse -> overflow=0.
6. FIFO full, new gpio_out change coinciding with host_ready=1 -> count stays 8, overflow=0, new word at tail. Then rst=0 mid-drain -> count=0, host_valid=0 immediately (asynchronous).
